// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage types and instruction field positions
// Purpose: fetch FSM state type, MIPS-style field bit positions, default reset PC.
// Ports: none (package).
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } fetch_state_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory read bus
// Purpose: groups the word-read handshake between the fetch unit and instruction memory.
// Signals: mem_req (fetch->mem), mem_addr (fetch->mem), mem_ack (mem->fetch), mem_rdata (mem->fetch).
// Modports: master = fetch unit side, slave = memory side.
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/instr_reg.sv
// rtl/instr_reg.sv - instruction register with decoded field slices
// Purpose: holds IR, loads it from the fetch buffer on load, exposes fields combinationally.
// Ports: clk, rst (async active-low), load, d (word to load), ir, opcode, rs, rt, rd,
//        shamt, funct, imm16 (pure slices of ir).
module instr_reg
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] ir,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm16
);

  logic [DATA_W-1:0] ir_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q <= '0;
    end else if (load) begin
      ir_q <= d;
    end
  end

  assign ir     = ir_q;
  assign opcode = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign rs     = ir_q[RS_MSB:RS_LSB];
  assign rt     = ir_q[RT_MSB:RT_LSB];
  assign rd     = ir_q[RD_MSB:RD_LSB];
  assign shamt  = ir_q[SHAMT_MSB:SHAMT_LSB];
  assign funct  = ir_q[FUNCT_MSB:FUNCT_LSB];
  assign imm16  = ir_q[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, instruction memory read handshake and IR
// Purpose: fetch datapath driven by multicycle control strobes (pc_write, mem_read, ir_write).
// Ports: clk, rst (async active-low); pc_write, pc_src, branch_target (PC update);
//        mem_read (start fetch), ir_write (load IR); mem (memory read bus, master side);
//        pc, ir, opcode/rs/rt/rd/shamt/funct/imm16 (decode); instr_ready, stall, fetch_err.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC),
  parameter int unsigned       PC_INC   = 4,
  parameter int unsigned       TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_write,
  input  logic                pc_src,
  input  logic [ADDR_W-1:0]   branch_target,
  input  logic                mem_read,
  input  logic                ir_write,
  instr_fetch_unit_if.master  mem,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   ir,
  output logic [5:0]          opcode,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [4:0]          shamt,
  output logic [5:0]          funct,
  output logic [15:0]         imm16,
  output logic                instr_ready,
  output logic                stall,
  output logic                fetch_err
);

  // Abort on the cycle whose increment would reach TIMEOUT, so mem_req is
  // held for exactly TIMEOUT cycles without an ack.
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] buf_q;
  logic [3:0]        cnt_q;
  logic              err_q;

  logic addr_load, buf_load, cnt_clr, cnt_inc, err_set, ir_load;

  always_comb begin
    state_d   = state_q;
    addr_load = 1'b0;
    buf_load  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    err_set   = 1'b0;
    ir_load   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read) begin
          addr_load = 1'b1;
          cnt_clr   = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // An ack on the last allowed cycle still wins over the abort.
        if (mem.mem_ack) begin
          buf_load = 1'b1;
          state_d  = READY;
        end else if (cnt_q == CNT_LAST) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      READY: begin
        if (ir_write) begin
          ir_load = 1'b1;
          if (mem_read) begin
            addr_load = 1'b1;
            cnt_clr   = 1'b1;
            state_d   = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pc_write) begin
        pc_q <= pc_src ? branch_target : pc_q + ADDR_W'(PC_INC);
      end
      // Address copy taken from the pre-update PC so a same-cycle pc_write
      // does not leak into the request.
      if (addr_load) addr_q <= pc_q;
      if (buf_load)  buf_q  <= mem.mem_rdata;
      if (cnt_clr)        cnt_q <= '0;
      else if (cnt_inc)   cnt_q <= cnt_q + 4'd1;
      if (err_set)   err_q  <= 1'b1;
    end
  end

  // mem_req decodes straight from the state flop so an async reset drops it at once.
  assign mem.mem_req  = (state_q == BUSY);
  assign mem.mem_addr = addr_q;

  assign pc          = pc_q;
  assign instr_ready = (state_q == READY);
  assign stall       = ir_write && (state_q != READY);
  assign fetch_err   = err_q;

  instr_reg #(.DATA_W(DATA_W)) u_instr_reg (
    .clk    (clk),
    .rst    (rst),
    .load   (ir_load),
    .d      (buf_q),
    .ir     (ir),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imm16  (imm16)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        mem_read;
  logic        ir_write;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic        instr_ready;
  logic        stall;
  logic        fetch_err;

  instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .mem_read      (mem_read),
    .ir_write      (ir_write),
    .mem           (mem_bus.master),
    .pc            (pc),
    .ir            (ir),
    .opcode        (opcode),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .shamt         (shamt),
    .funct         (funct),
    .imm16         (imm16),
    .instr_ready   (instr_ready),
    .stall         (stall),
    .fetch_err     (fetch_err)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] exp_pc;
  logic [31:0] exp_ir;
  logic        exp_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Field expectations derived arithmetically from the word.
  task automatic check_ir(input string tag);
    check({tag, " ir"},     ir,              exp_ir);
    check({tag, " opcode"}, 32'(opcode),     (exp_ir / 32'h0400_0000) % 64);
    check({tag, " rs"},     32'(rs),         (exp_ir / 32'h0020_0000) % 32);
    check({tag, " rt"},     32'(rt),         (exp_ir / 32'h0001_0000) % 32);
    check({tag, " rd"},     32'(rd),         (exp_ir / 32'h0000_0800) % 32);
    check({tag, " shamt"},  32'(shamt),      (exp_ir / 32'h0000_0040) % 32);
    check({tag, " funct"},  32'(funct),      exp_ir % 64);
    check({tag, " imm16"},  32'(imm16),      exp_ir % 65536);
  endtask

  task automatic pc_op(input logic src, input logic [31:0] tgt);
    pc_write = 1'b1; pc_src = src; branch_target = tgt;
    tick();
    pc_write = 1'b0; pc_src = 1'b0;
    exp_pc = src ? tgt : exp_pc + 32'd4;
  endtask

  // Full fetch: request, wait lat cycles, ack with data, load IR.
  task automatic fetch(input string tag, input logic [31:0] data, input int lat, input bit pc_noise);
    logic [31:0] req_addr;
    req_addr = exp_pc;
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    check({tag, " req"},  32'(mem_bus.mem_req), 32'd1);
    check({tag, " addr"}, mem_bus.mem_addr, req_addr);
    for (int i = 0; i < lat; i++) begin
      if (pc_noise && ($urandom % 2 == 1)) begin
        pc_op(1'($urandom % 2), $urandom & 32'hFFFF_FFFC);
      end else begin
        tick();
      end
    end
    check({tag, " addr held"}, mem_bus.mem_addr, req_addr);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = data;
    tick();
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = $urandom;
    check({tag, " ready"}, 32'(instr_ready), 32'd1);
    check({tag, " req low"}, 32'(mem_bus.mem_req), 32'd0);
    ir_write = 1'b1;
    #1;
    check({tag, " no stall"}, 32'(stall), 32'd0);
    tick();
    ir_write = 1'b0;
    exp_ir = data;
    check_ir(tag);
    check({tag, " ready clr"}, 32'(instr_ready), 32'd0);
    check({tag, " pc"}, pc, exp_pc);
    check({tag, " err"}, 32'(fetch_err), 32'(exp_err));
  endtask

  initial begin
    rst = 1'b0; pc_write = 1'b0; pc_src = 1'b0; branch_target = '0;
    mem_read = 1'b0; ir_write = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    exp_pc = 32'h0; exp_ir = 32'h0; exp_err = 1'b0;

    // 1: reset state and a basic fetch
    tick(); tick();
    check("rst pc",    pc, 32'h0);
    check("rst ir",    ir, 32'h0);
    check("rst req",   32'(mem_bus.mem_req), 32'd0);
    check("rst ready", 32'(instr_ready), 32'd0);
    check("rst err",   32'(fetch_err), 32'd0);
    rst = 1'b1;
    tick();
    fetch("t1", 32'h8C22_0004, 0, 1'b0);
    check("t1 opcode lit", 32'(opcode), 32'h23);
    check("t1 rs lit",     32'(rs), 32'd1);
    check("t1 rt lit",     32'(rt), 32'd2);
    check("t1 imm lit",    32'(imm16), 32'd4);

    // 2: PC sequencing and wrap
    pc_op(1'b0, 32'h0); pc_op(1'b0, 32'h0); pc_op(1'b0, 32'h0);
    check("t2 pc inc3", pc, 32'h0000_000C);
    pc_op(1'b1, 32'hFFFF_FFFC);
    check("t2 pc max", pc, 32'hFFFF_FFFC);
    pc_op(1'b0, 32'h0);
    check("t2 pc wrap", pc, 32'h0);
    pc_op(1'b1, 32'h0000_0400);
    check("t2 pc branch", pc, 32'h0000_0400);

    // 3: timeout, then a later fetch still works with fetch_err sticky
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      check($sformatf("t3 req cyc%0d", k), 32'(mem_bus.mem_req), 32'd1);
      check($sformatf("t3 err cyc%0d", k), 32'(fetch_err), 32'd0);
      tick();
    end
    check("t3 req drop", 32'(mem_bus.mem_req), 32'd0);
    check("t3 err set",  32'(fetch_err), 32'd1);
    check("t3 not ready", 32'(instr_ready), 32'd0);
    exp_err = 1'b1;
    tick();
    check("t3 idle req", 32'(mem_bus.mem_req), 32'd0);
    fetch("t3 refetch", 32'h0123_4567, 2, 1'b0);

    // 4: ir_write while BUSY stalls and leaves IR alone
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    ir_write = 1'b1;
    #1;
    check("t4 stall busy", 32'(stall), 32'd1);
    tick();
    ir_write = 1'b0;
    check("t4 ir kept", ir, exp_ir);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'h2008_FFFF;
    tick();
    mem_bus.mem_ack = 1'b0;
    ir_write = 1'b1;
    #1;
    check("t4 stall ready", 32'(stall), 32'd0);
    tick();
    ir_write = 1'b0;
    exp_ir = 32'h2008_FFFF;
    check_ir("t4 load");

    // 5: pc_write and extra mem_read during BUSY
    pc_op(1'b1, 32'h0000_0010);
    mem_read = 1'b1;
    tick();
    mem_read = 1'b1; pc_write = 1'b1; pc_src = 1'b0;
    tick();
    mem_read = 1'b0; pc_write = 1'b0;
    exp_pc = 32'h0000_0014;
    check("t5 addr stable", mem_bus.mem_addr, 32'h0000_0010);
    check("t5 pc moved",    pc, exp_pc);
    check("t5 req",         32'(mem_bus.mem_req), 32'd1);
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hAAAA_5555;
    tick();
    mem_bus.mem_ack = 1'b0;
    tick();
    check("t5 no 2nd req", 32'(mem_bus.mem_req), 32'd0);
    check("t5 ready",      32'(instr_ready), 32'd1);
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    exp_ir = 32'hAAAA_5555;
    check_ir("t5 load");
    check("t5 stays idle", 32'(mem_bus.mem_req), 32'd0);

    // randomized fetches against the model
    for (int n = 0; n < 40; n++) begin
      if ($urandom % 3 == 0) pc_op(1'($urandom % 2), $urandom & 32'hFFFF_FFFC);
      fetch($sformatf("rnd%0d", n), $urandom, int'($urandom_range(0, 6)), 1'b1);
    end

    // 6: async reset in the middle of BUSY
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    tick();
    check("t6 busy", 32'(mem_bus.mem_req), 32'd1);
    rst = 1'b0;
    #1;
    exp_pc = 32'h0; exp_ir = 32'h0; exp_err = 1'b0;
    check("t6 req drop", 32'(mem_bus.mem_req), 32'd0);
    check("t6 pc reset", pc, exp_pc);
    check("t6 err clr",  32'(fetch_err), 32'd0);
    tick();
    rst = 1'b1;
    mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_bus.mem_ack = 1'b0;
    check("t6 late ack ready", 32'(instr_ready), 32'd0);
    check("t6 late ack req",   32'(mem_bus.mem_req), 32'd0);
    ir_write = 1'b1;
    tick();
    ir_write = 1'b0;
    check("t6 ir zero", ir, exp_ir);
    fetch("t6 post", 32'h0000_0020, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
